// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the timer_counter device.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

    // FSM state encodings
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL.Mode codes; 10/11 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/tc_prescaler.sv
// tc_prescaler: count-tick generator, one tick every PRESCALE cycles while run is high.
// Latency: tick is combinational from the internal counter; first tick PRESCALE cycles after clear.
// Backpressure: none; run gates counting, clear restarts the divider.
// Ports: clk, reset (sync, active-high), run, clear -> tick.
// Only compiled when TC_PRESCALE_EN is defined.
`ifdef TC_PRESCALE_EN
module tc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    // At least one bit so PRESCALE=1 still yields a legal vector
    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pcnt;

    assign tick = run && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= tick ? '0 : pcnt + W'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter: programmable down-counting timer on the CPU device bus, one-shot or auto-reload.
// Latency: PRESET=N -> INT entered N+2 edges after the enabling CTRL write (N*PRESCALE+2 with prescaler).
// Backpressure: none; single-cycle register writes, combinational reads.
// Ports: Clk, Reset (sync, active-high), Addr[1:0] (0=CTRL 1=PRESET 2=COUNT 3=rsvd), We, Din[31:0],
//        Dout[31:0] (combinational read data), IRQ (IM & irq_flag, to cp0 HWInt).
// Build option: define TC_PRESCALE_EN to insert the tc_prescaler tick divider.
module timer_counter
    import timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        tick;

    logic       en;
    logic       im;
    logic       reload;
    logic       ctrl_wr;
    logic       preset_wr;
    logic       expire;

    assign en        = ctrl[CTRL_EN];
    assign im        = ctrl[CTRL_IM];
    assign reload    = is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign ctrl_wr   = We && (Addr == ADDR_CTRL);
    assign preset_wr = We && (Addr == ADDR_PRESET);

    // Covers both COUNT==1 (last decrement) and COUNT==0 (PRESET=0, no decrement)
    assign expire = (state == CNT) && en && tick && (count <= 32'd1);

`ifdef TC_PRESCALE_EN
    tc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (Clk),
        .reset (Reset),
        .run   (state == CNT),
        .clear (state == LOAD),
        .tick  (tick)
    );
`else
    // Every cycle is a tick; PRESCALE only guards against an illegal zero here.
    assign tick = (PRESCALE > 0);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            // A software CTRL write beats the one-shot hardware Enable clear
            if (ctrl_wr) begin
                ctrl <= Din[3:0];
            end else if ((state == INT) && !reload) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            // Takes effect at the next LOAD, never on the running count
            if (preset_wr) begin
                preset <= Din;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count <= 32'd1) begin
                            count <= 32'd0;
                            state <= INT;
                        end else begin
                            count <= count - 32'd1;
                        end
                    end
                end
                INT: begin
                    state <= reload ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase

            // Setting beats an acknowledge on the same edge; reload mode
            // keeps the flag for the single INT cycle only.
            if (expire) begin
                irq_flag <= 1'b1;
            end else if ((state == INT) && reload) begin
                irq_flag <= 1'b0;
            end else if (ctrl_wr || preset_wr) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr)
            ADDR_CTRL:   Dout = {28'd0, ctrl};
            ADDR_PRESET: Dout = preset;
            ADDR_COUNT:  Dout = count;
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_counter;

`ifdef TC_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic        Clk;
    logic        Reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int vectors;
    int miscompares;

    timer_counter #(
        .PRESCALE (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .We    (We),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Single register write; the write lands on the next rising edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        We   = 1'b1;
        @(posedge Clk);
        #1;
        We   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset = 1'b1;
        We    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;

        // ---- reset state
        cyc(2);
        rd_chk("rst_ctrl",   2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'd0);
        rd_chk("rst_count",  2'd2, 32'd0);
        rd_chk("rst_rsvd",   2'd3, 32'd0);
        irq_chk("rst_irq", 1'b0);
        Reset = 1'b0;
        cyc(1);

        // ---- one-shot, PRESET=5, IM=1
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                  // edge t
        cyc(2);
        rd_chk("os_count_loaded", 2'd2, 32'd5);
        cyc(5*P - 1);
        irq_chk("os_irq_before", 1'b0);
        rd_chk("os_count_one", 2'd2, 32'd1);
        cyc(1);                           // edge t+2+5P
        irq_chk("os_irq_rise", 1'b1);
        rd_chk("os_count_zero", 2'd2, 32'd0);
        cyc(1);
        rd_chk("os_ctrl_en_cleared", 2'd0, 32'h8);
        cyc(3);
        irq_chk("os_irq_held", 1'b1);
        wr(2'd0, 32'h0);
        irq_chk("os_irq_acked", 1'b0);

        // ---- auto-reload, PRESET=3: count 3,2,1 per tick, then INT(0), LOAD(0)
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        cyc(2);
        for (int i = 0; i < 2*(3*P + 2); i++) begin
            int ph;
            logic [31:0] ec;
            ph = i % (3*P + 2);
            ec = (ph < 3*P) ? 32'(3 - ph/P) : 32'd0;
            rd_chk($sformatf("ar_count[%0d]", i), 2'd2, ec);
            irq_chk($sformatf("ar_irq[%0d]", i), ph == 3*P);
            cyc(1);
        end

        // ---- PRESET=9 written mid-count: current expiry kept, next reload is 9
        wr(2'd1, 32'd9);
        cyc(3*P - 1);
        irq_chk("pw_expiry_unchanged", 1'b1);
        cyc(2);
        rd_chk("pw_reload_9", 2'd2, 32'd9);

        // ---- disable mid-count: COUNT holds at 7
        cyc(P);
        rd_chk("dis_count_8", 2'd2, 32'd8);
        cyc(P - 1);
        wr(2'd0, 32'h0);
        rd_chk("dis_count_7", 2'd2, 32'd7);
        cyc(6);
        rd_chk("dis_count_hold", 2'd2, 32'd7);
        irq_chk("dis_irq", 1'b0);

        // ---- writes to COUNT / reserved are ignored
        wr(2'd2, 32'h1234);
        rd_chk("ro_count_addr2", 2'd2, 32'd7);
        wr(2'd3, 32'h55AA);
        rd_chk("ro_count_addr3", 2'd2, 32'd7);
        rd_chk("ro_rsvd_zero", 2'd3, 32'd0);

        // ---- PRESET=0: INT without decrement, 2+P edges after enable
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        cyc(1 + P);
        irq_chk("p0_irq_before", 1'b0);
        cyc(1);
        irq_chk("p0_irq_rise", 1'b1);
        wr(2'd0, 32'h0);
        irq_chk("p0_irq_acked", 1'b0);

        // ---- masked expiry: flag set but IRQ stays low
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        cyc(2 + 2*P);
        irq_chk("mk_irq_at_expiry", 1'b0);
        cyc(4);
        irq_chk("mk_irq_later", 1'b0);
        rd_chk("mk_ctrl_cleared", 2'd0, 32'h0);

        // IM written on the very edge INT is entered: set beats acknowledge
        wr(2'd0, 32'h1);
        cyc(1 + 2*P);
        wr(2'd0, 32'h8);
        irq_chk("mk_set_wins", 1'b1);
        // CTRL write on the INT exit edge beats the hardware Enable clear
        wr(2'd0, 32'h9);
        rd_chk("sw_ctrl_wins", 2'd0, 32'h9);
        irq_chk("sw_write_acks", 1'b0);
        cyc(1 + 2*P);
        irq_chk("rearm_irq_before", 1'b0);
        cyc(1);
        irq_chk("rearm_irq_rise", 1'b1);
        wr(2'd0, 32'h0);

        // ---- reset mid-count at COUNT=4
        wr(2'd1, 32'd6);
        wr(2'd0, 32'hB);
        cyc(2 + 2*P);
        rd_chk("mr_count_4", 2'd2, 32'd4);
        Reset = 1'b1;
        cyc(1);
        rd_chk("mr_ctrl",   2'd0, 32'd0);
        rd_chk("mr_preset", 2'd1, 32'd0);
        rd_chk("mr_count",  2'd2, 32'd0);
        irq_chk("mr_irq", 1'b0);
        Reset = 1'b0;
        cyc(10);
        rd_chk("mr_idle_count", 2'd2, 32'd0);
        irq_chk("mr_idle_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
